pipelined_logical_reducer: RTL and testbench

PIPELINED_LOGICAL_REDUCER -- requirements
Module: pipelined_logical_reducer

---
 rtl/pipelined_logical_reducer_pkg.sv | 49 ++++
 rtl/pipelined_logical_reducer_beat_reduce.sv | 32 +++
 rtl/pipelined_logical_reducer.sv | 135 +++++++++++++
 tb/tb_pipelined_logical_reducer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_logical_reducer_pkg.sv
// Shared types for the pipelined logical reducer: reduction modes, packet
// state and helpers that map an op code and accumulated flags to a result.
package pipelined_logical_reducer_pkg;

    typedef enum logic [2:0] {
        MODE_OR   = 3'd0,
        MODE_AND  = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NOR  = 3'd3,
        MODE_NAND = 3'd4,
        MODE_XNOR = 3'd5
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Unassigned op codes fall back to OR.
    function automatic mode_e decode_mode(input logic [2:0] op);
        mode_e m;
        case (op)
            3'd1:    m = MODE_AND;
            3'd2:    m = MODE_XOR;
            3'd3:    m = MODE_NOR;
            3'd4:    m = MODE_NAND;
            3'd5:    m = MODE_XNOR;
            default: m = MODE_OR;
        endcase
        return m;
    endfunction

    function automatic logic reduce_result(input mode_e mode,
                                           input logic any_true,
                                           input logic all_true,
                                           input logic parity);
        logic r;
        case (mode)
            MODE_AND:  r = all_true;
            MODE_XOR:  r = parity;
            MODE_NOR:  r = !any_true;
            MODE_NAND: r = !all_true;
            MODE_XNOR: r = !parity;
            default:   r = any_true;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipelined_logical_reducer_beat_reduce.sv
// Combinational reduction of one beat of M operands to the flags and
// nonzero-operand count that the packet accumulators consume.
module logical_beat_reduce #(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int BW = $clog2(M + 1)
) (
    input  logic [M*N-1:0] data,
    output logic           any_true,
    output logic           all_true,
    output logic           parity,
    output logic [BW-1:0]  nonzero_count
);

    logic op_true;

    always_comb begin
        any_true      = 1'b0;
        all_true      = 1'b1;
        parity        = 1'b0;
        nonzero_count = '0;
        op_true       = 1'b0;
        for (int k = 0; k < M; k++) begin
            op_true       = |data[k*N +: N];
            any_true      = any_true | op_true;
            all_true      = all_true & op_true;
            parity        = parity ^ op_true;
            nonzero_count = nonzero_count + BW'(op_true);
        end
    end

endmodule

// File: rtl/pipelined_logical_reducer.sv
// Packet-level logical reducer: folds per-beat operand flags across a packet
// and presents the result, nonzero count and beat count in an output register.
module pipelined_logical_reducer
    import pipelined_logical_reducer_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M*N-1:0] in_data,
    input  logic          in_last,
    input  logic [2:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_result,
    output logic [CW-1:0] out_count,
    output logic [CW-1:0] out_beats
);

    localparam int BW = $clog2(M + 1);
    localparam int SW = ((CW > BW) ? CW : BW) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_e        state;
    state_e        state_next;
    mode_e         acc_mode;
    logic          acc_any;
    logic          acc_all;
    logic          acc_par;
    logic [CW-1:0] acc_count;
    logic [CW-1:0] acc_beats;

    logic          beat_any;
    logic          beat_all;
    logic          beat_par;
    logic [BW-1:0] beat_count;

    logic          accept;
    logic          first_beat;
    mode_e         mode_cur;
    logic          new_any;
    logic          new_all;
    logic          new_par;
    logic [SW-1:0] count_sum;
    logic [CW-1:0] new_count;
    logic [CW-1:0] new_beats;
    logic          new_result;

    logical_beat_reduce #(
        .N  (N),
        .M  (M),
        .BW (BW)
    ) u_beat_reduce (
        .data          (in_data),
        .any_true      (beat_any),
        .all_true      (beat_all),
        .parity        (beat_par),
        .nonzero_count (beat_count)
    );

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign first_beat = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = in_last ? IDLE : ACCUM;
        end
    end

    // On the first beat the stale accumulators are replaced by identity values
    // so nothing from a previous or aborted packet can leak in.
    always_comb begin
        mode_cur   = first_beat ? decode_mode(in_op) : acc_mode;
        new_any    = (first_beat ? 1'b0 : acc_any) | beat_any;
        new_all    = (first_beat ? 1'b1 : acc_all) & beat_all;
        new_par    = (first_beat ? 1'b0 : acc_par) ^ beat_par;
        count_sum  = SW'(first_beat ? '0 : acc_count) + SW'(beat_count);
        new_count  = (count_sum > SW'(CNT_MAX)) ? CNT_MAX : CW'(count_sum);
        new_beats  = CW'(1);
        if (!first_beat) begin
            new_beats = (acc_beats == CNT_MAX) ? CNT_MAX : acc_beats + CW'(1);
        end
        new_result = reduce_result(mode_cur, new_any, new_all, new_par);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_mode  <= MODE_OR;
            acc_any   <= 1'b0;
            acc_all   <= 1'b0;
            acc_par   <= 1'b0;
            acc_count <= '0;
            acc_beats <= '0;
        end else if (accept && !in_last) begin
            acc_mode  <= mode_cur;
            acc_any   <= new_any;
            acc_all   <= new_all;
            acc_par   <= new_par;
            acc_count <= new_count;
            acc_beats <= new_beats;
        end
    end

    // A last beat may load while the previous result drains in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 1'b0;
            out_count  <= '0;
            out_beats  <= '0;
        end else if (accept && in_last) begin
            out_valid  <= 1'b1;
            out_result <= new_result;
            out_count  <= new_count;
            out_beats  <= new_beats;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_logical_reducer.sv
// Directed scoreboard bench for pipelined_logical_reducer: a default-size
// instance plus a CW=2 instance for counter saturation.
module tb_pipelined_logical_reducer;

    typedef struct {
        logic        result;
        logic [15:0] count;
        logic [15:0] beats;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic        out_result;
    logic [15:0] out_count;
    logic [15:0] out_beats;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_data;
    logic        s_in_last;
    logic [2:0]  s_in_op;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_out_result;
    logic [1:0]  s_out_count;
    logic [1:0]  s_out_beats;

    exp_t exp_q[$];
    exp_t sat_q[$];
    int   total = 0;
    int   bad   = 0;

    pipelined_logical_reducer #(.N(8), .M(4), .CW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_count  (out_count),
        .out_beats  (out_beats)
    );

    pipelined_logical_reducer #(.N(8), .M(4), .CW(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .in_last    (s_in_last),
        .in_op      (s_in_op),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_result (s_out_result),
        .out_count  (s_out_count),
        .out_beats  (s_out_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit which, input logic result,
                            input logic [15:0] count, input logic [15:0] beats);
        exp_t e;
        e.result = result;
        e.count  = count;
        e.beats  = beats;
        if (which) sat_q.push_back(e);
        else exp_q.push_back(e);
    endtask

    // Holds a beat until the selected DUT accepts it; returns just after that edge.
    task automatic apply_stimulus(input bit which, input logic [31:0] data,
                                  input logic last, input logic [2:0] op);
        int waited;
        bit ok;
        if (which) begin
            s_in_valid = 1'b1; s_in_data = data; s_in_last = last; s_in_op = op;
        end else begin
            in_valid = 1'b1; in_data = data; in_last = last; in_op = op;
        end
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if ((which && s_in_ready) || (!which && in_ready)) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        tick();
        if (which) s_in_valid = 1'b0;
        else in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_output: got result=%0d count=%0d expected none",
                         out_result, out_count);
            end else begin
                e = exp_q.pop_front();
                check_value("result", 32'(out_result), 32'(e.result));
                check_value("count", 32'(out_count), 32'(e.count));
                check_value("beats", 32'(out_beats), 32'(e.beats));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_out_valid && s_out_ready) begin
            if (sat_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sat_unexpected_output: got result=%0d expected none",
                         s_out_result);
            end else begin
                e = sat_q.pop_front();
                check_value("sat_result", 32'(s_out_result), 32'(e.result));
                check_value("sat_count", 32'(s_out_count), 32'(e.count));
                check_value("sat_beats", 32'(s_out_beats), 32'(e.beats));
            end
        end
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_op = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_in_op = '0; s_out_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) tick();
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_out_result", 32'(out_result), 32'd0);
        check_value("rst_out_count", 32'(out_count), 32'd0);
        check_value("rst_out_beats", 32'(out_beats), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_value("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Single-beat OR packet with one-cycle latency.
        push_exp(0, 1'b1, 16'd1, 16'd1);
        apply_stimulus(0, 32'h0000_0001, 1'b1, 3'd0);
        check_value("latency_out_valid", 32'(out_valid), 32'd1);
        tick();

        push_exp(0, 1'b0, 16'd11, 16'd3);
        apply_stimulus(0, 32'h0101_0101, 1'b0, 3'd1);
        apply_stimulus(0, 32'hFF00_FFFF, 1'b0, 3'd1);
        apply_stimulus(0, 32'h8080_8080, 1'b1, 3'd1);

        push_exp(0, 1'b1, 16'd11, 16'd3);
        apply_stimulus(0, 32'h0101_0101, 1'b0, 3'd4);
        apply_stimulus(0, 32'hFF00_FFFF, 1'b0, 3'd4);
        apply_stimulus(0, 32'h8080_8080, 1'b1, 3'd4);

        // Op change on the second beat must not switch XOR to AND.
        push_exp(0, 1'b1, 16'd3, 16'd2);
        apply_stimulus(0, 32'h0100_0000, 1'b0, 3'd2);
        apply_stimulus(0, 32'h0000_0101, 1'b1, 3'd1);

        push_exp(0, 1'b1, 16'd0, 16'd1);
        apply_stimulus(0, 32'h0000_0000, 1'b1, 3'd3);
        push_exp(0, 1'b1, 16'd2, 16'd2);
        apply_stimulus(0, 32'h0000_0001, 1'b0, 3'd5);
        apply_stimulus(0, 32'h0000_0100, 1'b1, 3'd5);
        push_exp(0, 1'b0, 16'd0, 16'd1);
        apply_stimulus(0, 32'h0000_0000, 1'b1, 3'd7);
        push_exp(0, 1'b1, 16'd1, 16'd1);
        apply_stimulus(0, 32'hFF00_0000, 1'b1, 3'd6);
        tick();

        // Backpressure: result held for five cycles, then drain and reload together.
        out_ready = 1'b0;
        push_exp(0, 1'b1, 16'd1, 16'd1);
        apply_stimulus(0, 32'h0000_FF00, 1'b1, 3'd0);
        for (int i = 0; i < 5; i++) begin
            check_value("stall_out_valid", 32'(out_valid), 32'd1);
            check_value("stall_out_count", 32'(out_count), 32'd1);
            check_value("stall_out_result", 32'(out_result), 32'd1);
            check_value("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        push_exp(0, 1'b1, 16'd4, 16'd1);
        in_valid = 1'b1; in_data = 32'h0303_0303; in_last = 1'b1; in_op = 3'd1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_value("b2b_out_valid", 32'(out_valid), 32'd1);
        check_value("b2b_out_count", 32'(out_count), 32'd4);
        tick();
        check_value("drained_out_valid", 32'(out_valid), 32'd0);

        // Abort an open packet with an asynchronous reset pulse.
        apply_stimulus(0, 32'h0000_0000, 1'b0, 3'd1);
        apply_stimulus(0, 32'h0000_0000, 1'b0, 3'd1);
        #2 rst = 1'b1;
        #1;
        check_value("async_rst_count", 32'(out_count), 32'd0);
        check_value("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_value("post_abort_out_valid", 32'(out_valid), 32'd0);
        check_value("post_abort_in_ready", 32'(in_ready), 32'd1);
        push_exp(0, 1'b1, 16'd4, 16'd1);
        apply_stimulus(0, 32'hFFFF_FFFF, 1'b1, 3'd1);

        // Saturating counters on the CW=2 instance; result stays exact.
        push_exp(1, 1'b1, 16'd3, 16'd3);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 32'hFFFF_FFFF, (i == 4), 3'd1);
        push_exp(1, 1'b0, 16'd3, 16'd3);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 32'h0101_0101, (i == 4), 3'd2);

        for (int i = 0; i < 20 && (exp_q.size() + sat_q.size()) != 0; i++) tick();
        check_value("queues_drained", 32'(exp_q.size() + sat_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
